// File: rtl/seq_mult_16_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_mult_16_pkg -- shared FSM states and sizing for seq_mult_16    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package seq_mult_16_pkg;

  localparam int OPW  = 16;
  localparam int ITER = 16;
  localparam int CNTW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult_16_cla.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Sixteen_bit_CLA -- 16-bit two-level carry-lookahead adder          |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module Sixteen_bit_CLA (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        Cin_MSB
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [15:0] w_c;
  logic [3:0]  w_gp;
  logic [3:0]  w_gg;
  logic [4:0]  w_cg;

  assign w_p = A ^ B;
  assign w_g = A & B;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B0 = 4 * gi;
      assign w_gp[gi] = &w_p[B0+3:B0];
      assign w_gg[gi] = w_g[B0+3]
                      | (w_p[B0+3] & w_g[B0+2])
                      | (w_p[B0+3] & w_p[B0+2] & w_g[B0+1])
                      | (w_p[B0+3] & w_p[B0+2] & w_p[B0+1] & w_g[B0]);
      assign w_c[B0]   = w_cg[gi];
      assign w_c[B0+1] = w_g[B0] | (w_p[B0] & w_cg[gi]);
      assign w_c[B0+2] = w_g[B0+1] | (w_p[B0+1] & w_g[B0])
                       | (w_p[B0+1] & w_p[B0] & w_cg[gi]);
      assign w_c[B0+3] = w_g[B0+2] | (w_p[B0+2] & w_g[B0+1])
                       | (w_p[B0+2] & w_p[B0+1] & w_g[B0])
                       | (w_p[B0+2] & w_p[B0+1] & w_p[B0] & w_cg[gi]);
    end
  endgenerate

  // Second-level lookahead across the four 4-bit groups
  assign w_cg[0] = Cin;
  assign w_cg[1] = w_gg[0] | (w_gp[0] & Cin);
  assign w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & Cin);
  assign w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & Cin);
  assign w_cg[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & Cin);

  assign Sum     = w_p ^ w_c;
  assign Cout    = w_cg[4];
  assign Cin_MSB = w_c[15];

endmodule
`default_nettype wire

// File: rtl/seq_mult_16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_mult_16 -- 16x16 unsigned shift-add multiplier, 16 iterations  |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module seq_mult_16 #(
  parameter int OPW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [OPW-1:0]     a,
  input  logic [OPW-1:0]     b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*OPW-1:0]   product
);
  import seq_mult_16_pkg::*;

  generate
    if (OPW != 16) begin : g_opw_check
      $error("seq_mult_16: only OPW=16 is supported");
    end
  endgenerate

  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(ITER - 1);

  state_t             state_q, state_d;
  logic [OPW-1:0]     m_q, m_d;
  logic [OPW-1:0]     q_q, q_d;
  logic [OPW-1:0]     acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*OPW-1:0]   product_q, product_d;

  logic [OPW-1:0]     cla_sum;
  logic               cla_cout;
  logic [OPW:0]       sum17;

  Sixteen_bit_CLA u_cla (
    .A       (acc_q),
    .B       (m_q),
    .Cin     (1'b0),
    .Sum     (cla_sum),
    .Cout    (cla_cout),
    .Cin_MSB ()
  );

  assign sum17 = q_q[0] ? {cla_cout, cla_sum} : {1'b0, acc_q};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        // Shift {SUM,Q} right by one: SUM's LSB becomes Q's MSB
        acc_d = sum17[OPW:1];
        q_d   = {sum17[0], q_q[OPW-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d   = DONE;
          product_d = {sum17, q_q[OPW-1:1]};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
`default_nettype wire
